// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants and types for the keyboard decoder and buffer.
package kbd_pkg;
    typedef logic [7:0] byte_t;
    localparam byte_t KEY_NONE       = 8'h00;
    localparam byte_t ASCII_NONE     = 8'h00;
    localparam int    KBD_FIFO_DEPTH = 16;
endpackage

// File: rtl/kbd_buffer_if.sv
// kbd_buffer_if: CPU keyboard-port bus; master is the CPU side, slave is the buffer.
interface kbd_buffer_if #(parameter int DEPTH = 16);
    import kbd_pkg::*;
    localparam int AW = $clog2(DEPTH);
    logic          rd_en;
    logic          clr_overflow;
    byte_t         rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    modport master (output rd_en, clr_overflow, input rd_data, empty, full, count, overflow);
    modport slave  (input rd_en, clr_overflow, output rd_data, empty, full, count, overflow);
endinterface

// File: rtl/kbd_buffer_sync_fifo.sv
// sync_fifo: generic show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rptr_q, wptr_q;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;
    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;
    assign count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= pop_ok  ? rptr_q + AW'(1) : rptr_q;
            wptr_q  <= push_ok ? wptr_q + AW'(1) : wptr_q;
            count_q <= count_d;
        end
    end
    // Storage is deliberately left out of reset.
    always_ff @(posedge clk)
        if (push_ok) mem_q[wptr_q] <= din_i;
endmodule

// File: rtl/kbd_buffer.sv
// kbd_buffer: queues one ASCII character per new key press for the CPU keyboard port.
module kbd_buffer import kbd_pkg::*; #(
    parameter int DEPTH = KBD_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           clrn,
    input  byte_t          current_key,
    input  byte_t          ascii_key,
    kbd_buffer_if.slave    bus
);
    byte_t prev_key_q;
    logic  overflow_q, overflow_d, press, ovf_evt;
    assign press      = current_key != prev_key_q && current_key != KEY_NONE && ascii_key != ASCII_NONE;
    assign ovf_evt    = press && bus.full && !bus.rd_en;
    assign overflow_d = ovf_evt ? 1'b1 : bus.clr_overflow ? 1'b0 : overflow_q;
    assign bus.overflow = overflow_q;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            prev_key_q <= KEY_NONE;
            overflow_q <= 1'b0;
        end else begin
            prev_key_q <= current_key;
            overflow_q <= overflow_d;
        end
    end
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .push_i  (press),
        .din_i   (ascii_key),
        .pop_i   (bus.rd_en),
        .dout_o  (bus.rd_data),
        .count_o (bus.count),
        .empty_o (bus.empty),
        .full_o  (bus.full)
    );
endmodule

// File: tb/tb_kbd_buffer.sv
// tb_kbd_buffer: directed vector table plus hand-written full/overflow/reset sequences.
module tb_kbd_buffer;
    import kbd_pkg::*;
    typedef struct {
        byte_t cur, asc;
        logic  rd, clr;
        int    cnt;
        logic  emp, ful, ovf;
        int    dat;
    } vec_t;
    logic  clk = 1'b0;
    logic  clrn = 1'b1;
    byte_t current_key = 8'h00;
    byte_t ascii_key = 8'h00;
    byte_t kc;
    int    checks = 0;
    int    errors = 0;
    vec_t  v[$];
    kbd_buffer_if bus();
    kbd_buffer dut (.clk(clk), .clrn(clrn), .current_key(current_key), .ascii_key(ascii_key), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic status(input string nm, input int cnt, input logic e, input logic f, input logic o);
        chk({nm, " count"}, int'(bus.count), cnt);
        chk({nm, " empty"}, int'(bus.empty), int'(e));
        chk({nm, " full"}, int'(bus.full), int'(f));
        chk({nm, " overflow"}, int'(bus.overflow), int'(o));
    endtask
    task automatic step(input byte_t c, input byte_t a, input logic r, input logic cl);
        current_key = c;
        ascii_key = a;
        bus.rd_en = r;
        bus.clr_overflow = cl;
        @(posedge clk);
        #1;
    endtask
    task automatic add(input byte_t c, input byte_t a, input logic r, input logic cl,
                       input int n, input logic e, input logic f, input logic o, input int d);
        v.push_back('{c, a, r, cl, n, e, f, o, d});
    endtask
    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            kc++;
            step(kc, kc, 1'b0, 1'b0);
        end
    endtask
    initial begin
        bus.rd_en = 1'b0;
        bus.clr_overflow = 1'b0;
        // test 1: long hold then release yields one entry
        add(8'h1C, 8'h61, 0, 0, 1, 0, 0, 0, 8'h61);
        for (int i = 0; i < 9; i++) add(8'h1C, 8'h61, 0, 0, 1, 0, 0, 0, 8'h61);
        add(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h61);
        add(8'h00, 8'h00, 1, 0, 0, 1, 0, 0, -1);
        // test 2: rollover press, modifier ignored
        add(8'h1C, 8'h61, 0, 0, 1, 0, 0, 0, 8'h61);
        add(8'h32, 8'h62, 0, 0, 2, 0, 0, 0, 8'h61);
        add(8'h12, 8'h00, 0, 0, 2, 0, 0, 0, 8'h61);
        add(8'h00, 8'h00, 0, 0, 2, 0, 0, 0, 8'h61);
        add(8'h00, 8'h00, 1, 0, 1, 0, 0, 0, 8'h62);
        add(8'h00, 8'h00, 1, 0, 0, 1, 0, 0, -1);
        // test 5: read while empty, push+pop while empty
        add(8'h00, 8'h00, 1, 0, 0, 1, 0, 0, -1);
        add(8'h1C, 8'h61, 1, 0, 1, 0, 0, 0, 8'h61);
        add(8'h00, 8'h00, 1, 0, 0, 1, 0, 0, -1);
        add(8'h00, 8'h00, 0, 1, 0, 1, 0, 0, -1);
        #2 clrn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        status("reset", 0, 1, 0, 0);
        clrn = 1'b1;
        foreach (v[i]) begin
            step(v[i].cur, v[i].asc, v[i].rd, v[i].clr);
            status($sformatf("v%0d", i), v[i].cnt, v[i].emp, v[i].ful, v[i].ovf);
            if (v[i].dat >= 0) chk($sformatf("v%0d rd_data", i), int'(bus.rd_data), v[i].dat);
        end
        // test 3: 17 presses, the 17th is dropped
        kc = 8'h2F;
        for (int i = 0; i < 16; i++) begin
            kc++;
            step(kc, kc, 1'b0, 1'b0);
            chk($sformatf("fill%0d count", i), int'(bus.count), i + 1);
        end
        status("full", 16, 0, 1, 0);
        kc++;
        step(kc, kc, 1'b0, 1'b0);
        status("drop", 16, 0, 1, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d rd_data", i), int'(bus.rd_data), 8'h30 + i);
            step(8'h00, 8'h00, 1'b1, 1'b0);
        end
        status("drained", 0, 1, 0, 1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        status("clr", 0, 1, 0, 0);
        // test 4: push+pop while full
        fill16();
        chk("refill head", int'(bus.rd_data), 8'h41);
        kc++;
        step(kc, kc, 1'b1, 1'b0);
        status("full push+pop", 16, 0, 1, 0);
        chk("full push+pop head", int'(bus.rd_data), 8'h42);
        kc++;
        step(kc, kc, 1'b0, 1'b0);
        status("full drop", 16, 0, 1, 1);
        // test 6: async reset mid-cycle with 5 entries and overflow set
        for (int i = 0; i < 11; i++) step(8'h00, 8'h00, 1'b1, 1'b0);
        status("five", 5, 0, 0, 1);
        #2 clrn = 1'b0;
        #1;
        status("async reset", 0, 1, 0, 0);
        #1 clrn = 1'b1;
        fill16();
        status("refill2", 16, 0, 1, 0);
        kc++;
        step(kc, kc, 1'b0, 1'b0);
        chk("ovf set", int'(bus.overflow), 1);
        kc++;
        step(kc, kc, 1'b0, 1'b1);
        chk("ovf set wins", int'(bus.overflow), 1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        status("ovf cleared", 16, 0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
